// File: rtl/image_pipe_buf.sv
`default_nettype none
// ============================================================================
// Module   : image_pipe_buf
// Purpose  : Show-ahead pixel FIFO with shift/narrow transform and frame count
// Revision : 1.0
// ============================================================================
module image_pipe_buf #(
    parameter int DW_IN  = 32,
    parameter int DW_OUT = 32,
    parameter int DEPTH  = 8,
    parameter int FCW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DW_IN-1:0]           is_data_in,
    input  logic                       is_valid_in,
    input  logic                       is_end_in,
    output logic                       is_busy_out,
    output logic [DW_OUT-1:0]          im_data_out,
    output logic                       im_valid_out,
    output logic                       im_end_out,
    input  logic                       im_busy_in,
    input  logic [5:0]                 cfg_shift,
    input  logic                       cfg_sat,
    output logic [FCW-1:0]             frame_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DW_OUT + 1;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_busy;
    logic              r_valid;
    logic [EW-1:0]     r_head;
    logic [FCW-1:0]    r_frame_cnt;

    logic              w_accept;
    logic              w_xfer;
    logic [DW_IN-1:0]  w_shifted;
    logic [DW_OUT-1:0] w_conv;
    logic [EW-1:0]     w_entry;
    logic [AW-1:0]     w_rd_next;
    logic [LW-1:0]     w_level_drain;
    logic [LW-1:0]     w_level_next;

    assign w_accept  = is_valid_in && !r_busy;
    assign w_xfer    = r_valid && !im_busy_in;
    // Logical shift already yields zero for shift amounts >= DW_IN.
    assign w_shifted = is_data_in >> cfg_shift;

    if (DW_OUT < DW_IN) begin : g_narrow
        logic w_over;
        assign w_over = |w_shifted[DW_IN-1:DW_OUT];
        assign w_conv = (cfg_sat && w_over) ? {DW_OUT{1'b1}} : w_shifted[DW_OUT-1:0];
    end else begin : g_widen
        logic w_unused_sat;
        assign w_unused_sat = cfg_sat;
        always_comb begin
            w_conv = '0;
            w_conv[DW_IN-1:0] = w_shifted;
        end
    end

    assign w_entry       = {is_end_in, w_conv};
    assign w_rd_next     = r_rd_ptr + AW'(w_xfer);
    assign w_level_drain = r_level - LW'(w_xfer);
    assign w_level_next  = w_level_drain + LW'(w_accept);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_head      <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
            r_busy   <= (w_level_next == LW'(DEPTH));
            r_valid  <= (w_level_next != '0);
            // Head register: an entry still buffered after this edge wins;
            // otherwise an accept into an empty buffer bypasses straight in.
            if (w_level_drain != '0) begin
                r_head <= r_mem[w_rd_next];
            end else if (w_accept) begin
                r_head <= w_entry;
            end
            if (w_xfer && r_head[DW_OUT]) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign is_busy_out  = r_busy;
    assign im_valid_out = r_valid;
    assign im_data_out  = r_head[DW_OUT-1:0];
    assign im_end_out   = r_head[DW_OUT];
    assign frame_cnt    = r_frame_cnt;
    assign level        = r_level;

endmodule
`default_nettype wire

// File: tb/tb_image_pipe_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_pipe_buf
// Purpose  : Scoreboard bench for image_pipe_buf (32->16 bits, depth 4, FCW 2)
// Revision : 1.0
// ============================================================================
module tb_image_pipe_buf;

    localparam int DW_IN  = 32;
    localparam int DW_OUT = 16;
    localparam int DEPTH  = 4;
    localparam int FCW    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW_IN-1:0]  is_data_in = '0;
    logic              is_valid_in = 1'b0;
    logic              is_end_in = 1'b0;
    logic              is_busy_out;
    logic [DW_OUT-1:0] im_data_out;
    logic              im_valid_out;
    logic              im_end_out;
    logic              im_busy_in = 1'b0;
    logic [5:0]        cfg_shift = '0;
    logic              cfg_sat = 1'b0;
    logic [FCW-1:0]    frame_cnt;
    logic [$clog2(DEPTH):0] level;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW_OUT:0] q[$];
    logic [FCW-1:0]  exp_frame = '0;
    logic            rand_busy = 1'b0;

    image_pipe_buf #(.DW_IN(DW_IN), .DW_OUT(DW_OUT), .DEPTH(DEPTH), .FCW(FCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .is_data_in(is_data_in), .is_valid_in(is_valid_in), .is_end_in(is_end_in),
        .is_busy_out(is_busy_out),
        .im_data_out(im_data_out), .im_valid_out(im_valid_out), .im_end_out(im_end_out),
        .im_busy_in(im_busy_in),
        .cfg_shift(cfg_shift), .cfg_sat(cfg_sat),
        .frame_cnt(frame_cnt), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW_OUT:0] model(input logic [31:0] d, input logic e,
                                              input logic [5:0] sh, input logic sat);
        logic [31:0] t;
        t = d >> sh;
        if (sat && (t[31:16] != 16'h0)) model = {e, 16'hFFFF};
        else                            model = {e, t[15:0]};
    endfunction

    // Monitor: compare current state against the model, then account for
    // the transfer/accept that the coming posedge will perform.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", 32'(level), 32'(q.size()));
            chk("busy",  32'(is_busy_out), 32'(q.size() == DEPTH));
            chk("valid", 32'(im_valid_out), 32'(q.size() != 0));
            chk("frame", 32'(frame_cnt), 32'(exp_frame));
            if (im_valid_out && q.size() != 0) begin
                chk("head", 32'({im_end_out, im_data_out}), 32'(q[0]));
                if (!im_busy_in) begin
                    if (q[0][DW_OUT]) exp_frame = exp_frame + 1'b1;
                    void'(q.pop_front());
                end
            end
            if (is_valid_in && !is_busy_out)
                q.push_back(model(is_data_in, is_end_in, cfg_shift, cfg_sat));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_busy) im_busy_in = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d, input logic e);
        logic acc;
        int   n;
        is_data_in  = d;
        is_end_in   = e;
        is_valid_in = 1'b1;
        acc = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            acc = !is_busy_out;
            tick();
            n++;
        end while (!acc && n < 200);
        chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle();
        is_valid_in = 1'b0;
        is_end_in   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || im_valid_out) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(im_valid_out), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_frame", 32'(frame_cnt), 32'd0);
        chk("rst_busy",  32'(is_busy_out), 32'd0);
        chk("rst_data",  32'({im_end_out, im_data_out}), 32'd0);
        q.delete();
        exp_frame = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] fseq [5];
        fseq[0] = 2'd1; fseq[1] = 2'd2; fseq[2] = 2'd3; fseq[3] = 2'd0; fseq[4] = 2'd1;

        tick();
        do_reset();

        // Show-ahead latency and saturation
        cfg_shift = 6'd0; cfg_sat = 1'b1;
        send(32'h0000_1234, 1'b0);
        idle();
        @(negedge clk);
        chk("lat_valid", 32'(im_valid_out), 32'd1);
        chk("lat_data",  32'(im_data_out), 32'h1234);
        tick();
        send(32'h0001_2345, 1'b0);
        idle();
        @(negedge clk);
        chk("sat_data", 32'(im_data_out), 32'hFFFF);
        tick();
        drain();

        // Truncation with shift, plus out-of-range shift
        cfg_sat = 1'b0; cfg_shift = 6'd4;
        send(32'h0012_3456, 1'b0);
        idle();
        @(negedge clk);
        chk("trunc_data", 32'(im_data_out), 32'h2345);
        tick();
        cfg_shift = 6'd40; cfg_sat = 1'b1;
        send(32'hFFFF_FFFF, 1'b0);
        idle();
        drain();

        // Backpressure fill, config change while buffered, release
        im_busy_in = 1'b1; cfg_shift = 6'd8; cfg_sat = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h1122_3340 + 32'(i), 1'b0);
        cfg_shift = 6'd0; cfg_sat = 1'b1;
        is_data_in = 32'h0000_5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_busy",  32'(is_busy_out), 32'd1);
            chk("full_level", 32'(level), 32'd4);
            tick();
        end
        im_busy_in = 1'b0;
        send(32'h0000_5555, 1'b0);
        idle();
        drain();

        // Three two-word frames under random downstream backpressure
        cfg_shift = 6'd0; cfg_sat = 1'b0;
        rand_busy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send(32'hA000 + 32'(f * 2), 1'b0);
            send(32'hA001 + 32'(f * 2), 1'b1);
        end
        idle();
        rand_busy = 1'b0;
        im_busy_in = 1'b0;
        drain();
        tick();
        @(negedge clk);
        chk("frames3", 32'(frame_cnt), 32'd3);

        // Frame counter wrap with FCW=2
        tick();
        do_reset();
        for (int f = 0; f < 5; f++) begin
            send(32'h00B0 + 32'(f), 1'b1);
            idle();
            drain();
            tick();
            @(negedge clk);
            chk("fseq", 32'(frame_cnt), 32'(fseq[f]));
            tick();
        end

        // Reset mid-stream discards buffered words
        im_busy_in = 1'b1;
        for (int i = 0; i < 3; i++) send(32'h0000_0C00 + 32'(i), 1'b0);
        idle();
        do_reset();
        im_busy_in = 1'b0;
        send(32'h0000_ABCD, 1'b0);
        idle();
        @(negedge clk);
        chk("post_rst_data", 32'(im_data_out), 32'hABCD);
        tick();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
